draw_rect_fill: RTL and testbench

Parametrised rectangle-fill engine for the hexagon renderer. It fills any axis-aligned rectangle in the frame buffer with one 32-bit colour, clipped to the screen. Rows are split into DDR bursts of at most BURST_LEN pixels, and the last burst of each row is shortened to fit. It sits between the top-level render sequencer and the DDR burst master, using the same txn_init/txn_done handshake as the full-screen background drawer.

---
 rtl/draw_rect_fill.sv | 158 +++++++++++++++
 tb/tb_draw_rect_fill.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/draw_rect_fill.sv
// rtl/draw_rect_fill.sv - clipped rectangle fill engine issuing row bursts to the DDR master
// Optional abort input is enabled by defining DRAW_RECT_FILL_ABORT_EN.
module draw_rect_fill #(
   parameter int SCREEN_W  = 640,
   parameter int SCREEN_H  = 480,
   parameter int BURST_LEN = 128,
   parameter int ROW_SHIFT = 12
) (
   input  logic        clk100,
   input  logic        reset,
   input  logic        draw,
`ifdef DRAW_RECT_FILL_ABORT_EN
   input  logic        abort,
`endif
   input  logic [11:0] x0,
   input  logic [11:0] y0,
   input  logic [11:0] w,
   input  logic [11:0] h,
   input  logic [31:0] color,
   output logic        busy,
   output logic        draw_done,
   output logic        txn_init,
   input  logic        txn_done,
   output logic [31:0] offset_addr,
   output logic [31:0] pixel_count,
   output logic [31:0] pixel_color
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] LATCH   = 3'd1;
   localparam logic [2:0] ISSUE   = 3'd2;
   localparam logic [2:0] ADVANCE = 3'd3;
   localparam logic [2:0] DONE    = 3'd4;

   logic [2:0]  state;
   logic        d1, d2, start;
   logic [11:0] cap_x0, cap_y0, cap_w, cap_h;
   logic [31:0] cap_color;
   logic [11:0] cx, cy;
   logic [12:0] xe, ye;
   logic [12:0] sum_x, sum_y, xe_c, ye_c, nx, cy_next;
   logic        empty_rect;
   logic        abort_now, abort_q;

`ifdef DRAW_RECT_FILL_ABORT_EN
   assign abort_now = abort;
`else
   assign abort_now = 1'b0;
`endif

   assign start = d1 & ~d2;

   // 13-bit sums so x0+w / y0+h can never wrap before clipping
   assign sum_x   = {1'b0, cap_x0} + {1'b0, cap_w};
   assign sum_y   = {1'b0, cap_y0} + {1'b0, cap_h};
   assign xe_c    = (sum_x > 13'(SCREEN_W)) ? 13'(SCREEN_W) : sum_x;
   assign ye_c    = (sum_y > 13'(SCREEN_H)) ? 13'(SCREEN_H) : sum_y;
   assign nx      = {1'b0, cx} + pixel_count[12:0];
   assign cy_next = {1'b0, cy} + 13'd1;

   assign empty_rect = (cap_w == 12'd0) || (cap_h == 12'd0) ||
                       ({1'b0, cap_x0} >= 13'(SCREEN_W)) ||
                       ({1'b0, cap_y0} >= 13'(SCREEN_H));

   function automatic logic [31:0] addr_of(input logic [11:0] x, input logic [11:0] y);
      return (32'(y) << ROW_SHIFT) + (32'(x) << 2);
   endfunction

   function automatic logic [31:0] count_of(input logic [11:0] x, input logic [12:0] end_x);
      logic [12:0] rem;
      rem = end_x - {1'b0, x};
      return (rem > 13'(BURST_LEN)) ? 32'(BURST_LEN) : 32'(rem);
   endfunction

   always_ff @(posedge clk100) begin
      if (reset) begin
         state       <= IDLE;
         d1          <= 1'b0;
         d2          <= 1'b0;
         busy        <= 1'b0;
         draw_done   <= 1'b0;
         txn_init    <= 1'b0;
         offset_addr <= 32'd0;
         pixel_count <= 32'd0;
         pixel_color <= 32'd0;
         cx          <= 12'd0;
         cy          <= 12'd0;
         xe          <= 13'd0;
         ye          <= 13'd0;
         cap_x0      <= 12'd0;
         cap_y0      <= 12'd0;
         cap_w       <= 12'd0;
         cap_h       <= 12'd0;
         cap_color   <= 32'd0;
         abort_q     <= 1'b0;
      end else begin
         d1 <= draw;
         d2 <= d1;
         // Status outputs are registered decodes of the current state
         busy      <= (state != IDLE);
         draw_done <= (state == DONE);
         txn_init  <= (state == ISSUE);

         case (state)
            IDLE: begin
               abort_q <= 1'b0;
               if (start) begin
                  cap_x0    <= x0;
                  cap_y0    <= y0;
                  cap_w     <= w;
                  cap_h     <= h;
                  cap_color <= color;
                  state     <= LATCH;
               end
            end
            LATCH: begin
               if (abort_now || empty_rect) begin
                  state <= DONE;
               end else begin
                  xe          <= xe_c;
                  ye          <= ye_c;
                  cx          <= cap_x0;
                  cy          <= cap_y0;
                  offset_addr <= addr_of(cap_x0, cap_y0);
                  pixel_count <= count_of(cap_x0, xe_c);
                  pixel_color <= cap_color;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               if (abort_now) abort_q <= 1'b1;
               if (txn_done) state <= (abort_q || abort_now) ? DONE : ADVANCE;
            end
            ADVANCE: begin
               if (abort_now) begin
                  state <= DONE;
               end else if (nx < xe) begin
                  cx          <= nx[11:0];
                  offset_addr <= addr_of(nx[11:0], cy);
                  pixel_count <= count_of(nx[11:0], xe);
                  state       <= ISSUE;
               end else if (cy_next == ye) begin
                  state <= DONE;
               end else begin
                  cx          <= cap_x0;
                  cy          <= cy_next[11:0];
                  offset_addr <= addr_of(cap_x0, cy_next[11:0]);
                  pixel_count <= count_of(cap_x0, xe);
                  state       <= ISSUE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_draw_rect_fill.sv
// tb/tb_draw_rect_fill.sv - self-checking bench for draw_rect_fill with a burst-list reference model
module tb_draw_rect_fill;

   logic        clk100 = 1'b0;
   logic        reset, draw, txn_done;
   logic [11:0] x0, y0, w, h;
   logic [31:0] color;
   logic        busy, draw_done, txn_init;
   logic [31:0] offset_addr, pixel_count, pixel_color;
`ifdef DRAW_RECT_FILL_ABORT_EN
   logic        abort;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] cnt;
   } burst_t;
   burst_t exp_q[$];

   always #5 clk100 = ~clk100;

   draw_rect_fill dut (
      .clk100      (clk100),
      .reset       (reset),
      .draw        (draw),
`ifdef DRAW_RECT_FILL_ABORT_EN
      .abort       (abort),
`endif
      .x0          (x0),
      .y0          (y0),
      .w           (w),
      .h           (h),
      .color       (color),
      .busy        (busy),
      .draw_done   (draw_done),
      .txn_init    (txn_init),
      .txn_done    (txn_done),
      .offset_addr (offset_addr),
      .pixel_count (pixel_count),
      .pixel_color (pixel_color)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: walk the clipped rectangle row by row in BURST_LEN steps
   task automatic build_model(input int xs, input int ys, input int ws, input int hs);
      int xe, ye;
      exp_q.delete();
      if (ws == 0 || hs == 0 || xs >= 640 || ys >= 480) return;
      xe = (xs + ws > 640) ? 640 : xs + ws;
      ye = (ys + hs > 480) ? 480 : ys + hs;
      for (int r = ys; r < ye; r++)
         for (int c = xs; c < xe; c += 128)
            exp_q.push_back('{addr: 32'(r * 4096 + c * 4), cnt: 32'((xe - c > 128) ? 128 : xe - c)});
   endtask

   // mode 0 normal, 1 mid-fill pokes, 2 reset in burst 3, 3 abort in burst 2
   task automatic run_fill(input int xs, input int ys, input int ws, input int hs,
                           input logic [31:0] col, input int maxd, input int mode);
      int cyc, nb, nexp, first_lat, done_lat, budget, hold;
      logic [31:0] held_addr;
      bit stop;
      build_model(xs, ys, ws, hs);
      nexp = exp_q.size();
      if (mode == 3 && nexp > 2) nexp = 2;
      budget = 40 + exp_q.size() * (maxd + 30);
      cyc = 0; nb = 0; first_lat = -1; done_lat = -1; stop = 0;
      @(negedge clk100);
      x0 = xs[11:0]; y0 = ys[11:0]; w = ws[11:0]; h = hs[11:0]; color = col;
      draw = 1'b1;
      while (done_lat < 0 && !stop && cyc < budget) begin
         @(negedge clk100); cyc++;
         if (draw_done) begin
            done_lat = cyc;
         end else if (txn_init) begin
            if (first_lat < 0) first_lat = cyc;
            check("burst_allowed", 32'(nb < nexp), 32'd1);
            if (nb < exp_q.size()) begin
               check("offset_addr", offset_addr, exp_q[nb].addr);
               check("pixel_count", pixel_count, exp_q[nb].cnt);
            end
            check("pixel_color", pixel_color, col);
            if (mode == 2 && nb == 2) begin
               reset = 1'b1; draw = 1'b0;
               @(negedge clk100);
               check("rst_busy", 32'(busy), 32'd0);
               check("rst_draw_done", 32'(draw_done), 32'd0);
               check("rst_txn_init", 32'(txn_init), 32'd0);
               check("rst_offset", offset_addr, 32'd0);
               check("rst_count", pixel_count, 32'd0);
               check("rst_color", pixel_color, 32'd0);
               reset = 1'b0;
               stop = 1;
            end else begin
               held_addr = offset_addr;
               hold = (mode == 1 && nb == 0) ? 20 : (mode == 3 && nb == 1) ? 3 : $urandom_range(0, maxd);
               for (int i = 0; i < hold; i++) begin
                  @(negedge clk100); cyc++;
                  if (mode == 1 && i == 5) begin draw = 1'b0; x0 = 12'd7; w = 12'd1; color = ~col; end
                  if (mode == 1 && i == 9) draw = 1'b1;
`ifdef DRAW_RECT_FILL_ABORT_EN
                  if (mode == 3) abort = (nb == 1 && i == 0);
`endif
                  check("init_held", 32'(txn_init), 32'd1);
                  check("offset_stable", offset_addr, held_addr);
               end
`ifdef DRAW_RECT_FILL_ABORT_EN
               abort = 1'b0;
`endif
               txn_done = 1'b1;
               @(negedge clk100); cyc++;
               txn_done = 1'b0;
               nb++;
               @(negedge clk100); cyc++;
               check("gap_low", 32'(txn_init), 32'd0);
               if (draw_done) done_lat = cyc;
            end
         end
      end
      if (mode != 2) begin
         check("done_seen", 32'(done_lat > 0), 32'd1);
         check("burst_total", 32'(nb), 32'(nexp));
         if (nexp == 0) check("empty_done_latency", 32'(done_lat), 32'd4);
         else           check("first_init_latency", 32'(first_lat), 32'd4);
         // draw still held high: the block must stay idle
         repeat (5) begin
            @(negedge clk100);
            check("no_restart", {29'd0, busy, txn_init, draw_done}, 32'd0);
         end
         draw = 1'b0;
      end
   endtask

   initial begin
      reset = 1'b1; draw = 1'b0; txn_done = 1'b0;
      x0 = 12'd0; y0 = 12'd0; w = 12'd0; h = 12'd0; color = 32'd0;
`ifdef DRAW_RECT_FILL_ABORT_EN
      abort = 1'b0;
`endif
      repeat (3) @(negedge clk100);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_draw_done", 32'(draw_done), 32'd0);
      check("reset_txn_init", 32'(txn_init), 32'd0);
      check("reset_offset", offset_addr, 32'd0);
      check("reset_count", pixel_count, 32'd0);
      check("reset_color", pixel_color, 32'd0);
      reset = 1'b0;
      @(negedge clk100);

      run_fill(0, 0, 640, 480, 32'hFF00FF00, 0, 0);
      run_fill(10, 5, 300, 1, 32'h12345678, 3, 0);
      run_fill(600, 0, 100, 2, 32'hCAFEBABE, 2, 0);
      run_fill(0, 0, 0, 5, 32'h0000000A, 0, 0);
      run_fill(640, 10, 5, 5, 32'h0000000B, 0, 0);
      run_fill(10, 5, 300, 1, 32'hDEADBEEF, 2, 1);
      run_fill(10, 5, 300, 1, 32'h55AA55AA, 1, 2);
      repeat (2) @(negedge clk100);
      run_fill(600, 0, 100, 2, 32'hA5A5A5A5, 1, 0);
`ifdef DRAW_RECT_FILL_ABORT_EN
      run_fill(10, 5, 300, 1, 32'h0BADF00D, 1, 3);
`endif
      for (int k = 0; k < 10; k++)
         run_fill($urandom_range(0, 700), $urandom_range(0, 490), $urandom_range(0, 400),
                  $urandom_range(0, 3), $urandom, 3, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
